// File: rtl/fc_pkg.sv
// Shared sign-magnitude Q15 arithmetic and state encodings for the fc layer and its loss stage.
// Word layout: bit N-1 is the sign, bits N-2:0 are the magnitude.
package fc_pkg;

  localparam int N = 32;
  localparam int Q = 15;
  localparam logic [N-1:0] Q_ONE = 32'h0000_8000;

  typedef enum logic [1:0] {
    LG_IDLE    = 2'd0,
    LG_COLLECT = 2'd1,
    LG_SEND    = 2'd2
  } lg_state_e;

  // Magnitude wraps on same-sign overflow; a zero result is always +0.
  function automatic logic [N-1:0] qadd(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] m;
    logic         s;
    if (a[N-1] == b[N-1]) begin
      m = a[N-2:0] + b[N-2:0];
      s = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      m = a[N-2:0] - b[N-2:0];
      s = a[N-1];
    end else begin
      m = b[N-2:0] - a[N-2:0];
      s = b[N-1];
    end
    return {s & (|m), m};
  endfunction

  function automatic logic [N-1:0] qmult(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] p;
    logic [N-2:0]   m;
    p = a[N-2:0] * b[N-2:0];
    m = (N-1)'(p >> Q);
    return {(a[N-1] ^ b[N-1]) & (|m), m};
  endfunction

  // Strict a > b; negative zero compares equal to +0.
  function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg, b_neg;
    a_neg = a[N-1] & (|a[N-2:0]);
    b_neg = b[N-1] & (|b[N-2:0]);
    if (!a_neg && b_neg) return 1'b1;
    if (a_neg && !b_neg) return 1'b0;
    if (!a_neg) return a[N-2:0] > b[N-2:0];
    return a[N-2:0] < b[N-2:0];
  endfunction

endpackage

// File: rtl/sm_argmax.sv
// Running sign-magnitude maximum; index 0 always seeds the max, ties keep the earlier index.
module sm_argmax
  import fc_pkg::*;
#(
  parameter int IW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [N-1:0]  val,
  input  logic [IW-1:0] idx,
  output logic [IW-1:0] max_idx,
  output logic [N-1:0]  max_val
);

  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [N-1:0]  max_val_q, max_val_d;

  always_comb begin
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (clear) begin
      max_idx_d = '0;
      max_val_d = '0;
    end else if (en && ((idx == '0) || sm_gt(val, max_val_q))) begin
      max_idx_d = idx;
      max_val_d = val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign max_idx = max_idx_q;
  assign max_val = max_val_q;

endmodule

// File: rtl/fc_loss_grad.sv
// Loss stage after fc: error = out - onehot(label), argmax prediction, error vector streamed back.
//   state      | meaning
//   LG_IDLE    | waiting for a label
//   LG_COLLECT | absorbing forward values, building error buffer and running max
//   LG_SEND    | streaming the error buffer upstream
module fc_loss_grad #(
  parameter int OUTPUT_WIDTH = 10,
  parameter int IDX_WIDTH    = 10,
  parameter int N            = 32,
  parameter int Q            = 15,
  parameter int LR_SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 label_valid,
  output logic                 label_rdy,
  input  logic [IDX_WIDTH-1:0] label,
  input  logic                 in_valid,
  output logic                 in_rdy,
  input  logic [N-1:0]         in_data,
  input  logic [IDX_WIDTH-1:0] in_idx,
  output logic                 out_valid,
  input  logic                 out_rdy,
  output logic [N-1:0]         out_data,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [IDX_WIDTH-1:0] pred,
  output logic                 pred_valid,
  output logic                 correct,
  output logic                 seq_err
);
  import fc_pkg::*;

  localparam logic [N-1:0]         ONE_W  = {{(N-1){1'b0}}, 1'b1} << Q;
  localparam logic [IDX_WIDTH-1:0] LAST   = IDX_WIDTH'(OUTPUT_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] N_OUTS = IDX_WIDTH'(OUTPUT_WIDTH);

  lg_state_e                          state_q, state_d;
  logic [IDX_WIDTH-1:0]               cnt_q, cnt_d, scnt_q, scnt_d, label_q, label_d;
  logic [IDX_WIDTH-1:0]               pred_q, pred_d;
  logic                               pred_valid_q, pred_valid_d, correct_q, correct_d;
  logic                               seq_err_q, seq_err_d;
  logic [OUTPUT_WIDTH-1:0][N-1:0]     err_q, err_d;

  logic                 am_clear, am_en;
  logic [IDX_WIDTH-1:0] am_max_idx, fin_idx;
  logic [N-1:0]         am_max_val, diff, err_val;
  logic [N-2:0]         err_mag;

  sm_argmax #(.IW(IDX_WIDTH)) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clear   (am_clear),
    .en      (am_en),
    .val     (in_data),
    .idx     (cnt_q),
    .max_idx (am_max_idx),
    .max_val (am_max_val)
  );

  // The last beat's own value must take part in pred, so resolve it here before it reaches the argmax register.
  always_comb begin
    diff    = qadd(in_data, (label_q == cnt_q) ? {1'b1, ONE_W[N-2:0]} : '0);
    err_mag = diff[N-2:0] >> LR_SHIFT;
    err_val = {diff[N-1] & (|err_mag), err_mag};
    fin_idx = ((cnt_q == '0) || sm_gt(in_data, am_max_val)) ? cnt_q : am_max_idx;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scnt_d       = scnt_q;
    label_d      = label_q;
    pred_d       = pred_q;
    pred_valid_d = 1'b0;
    correct_d    = correct_q;
    seq_err_d    = seq_err_q;
    err_d        = err_q;
    am_clear     = 1'b0;
    am_en        = 1'b0;
    case (state_q)
      LG_IDLE: begin
        if (label_valid) begin
          label_d  = label;
          cnt_d    = '0;
          am_clear = 1'b1;
          state_d  = LG_COLLECT;
        end
      end
      LG_COLLECT: begin
        if (in_valid) begin
          am_en = 1'b1;
          if (in_idx != cnt_q) seq_err_d = 1'b1;
          for (int i = 0; i < OUTPUT_WIDTH; i++) begin
            if (cnt_q == IDX_WIDTH'(i)) err_d[i] = err_val;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            pred_d       = fin_idx;
            correct_d    = (label_q < N_OUTS) && (fin_idx == label_q);
            pred_valid_d = 1'b1;
            scnt_d       = '0;
            state_d      = LG_SEND;
          end
        end
      end
      LG_SEND: begin
        if (out_rdy) begin
          if (scnt_q == LAST) begin
            scnt_d  = '0;
            state_d = LG_IDLE;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = LG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LG_IDLE;
      cnt_q        <= '0;
      scnt_q       <= '0;
      label_q      <= '0;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      correct_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scnt_q       <= scnt_d;
      label_q      <= label_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      correct_q    <= correct_d;
      seq_err_q    <= seq_err_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == LG_SEND) begin
      for (int i = 0; i < OUTPUT_WIDTH; i++) begin
        if (scnt_q == IDX_WIDTH'(i)) out_data = err_q[i];
      end
    end
  end

  assign label_rdy  = (state_q == LG_IDLE);
  assign in_rdy     = (state_q == LG_COLLECT);
  assign out_valid  = (state_q == LG_SEND);
  assign out_idx    = scnt_q;
  assign pred       = pred_q;
  assign pred_valid = pred_valid_q;
  assign correct    = correct_q;
  assign seq_err    = seq_err_q;

endmodule

// File: doc/fc_loss_grad.md
# fc_loss_grad

Output/loss stage placed directly downstream of the `fc` layer. Consumes the ReLU-rectified forward outputs (32-bit sign-magnitude Q15), takes a class label, and computes the per-output error `out - target` with a one-hot target of 1.0. It also computes the argmax prediction, then streams the error vector back upstream as the backprop input of `fc`.

## Interface
Parameters:
- `OUTPUT_WIDTH`, 10: number of class outputs; length of both the forward and the error vectors.
- `IDX_WIDTH`, 10: index width on every data port.
- `N`, 32: data word width, sign-magnitude.
- `Q`, 15: fractional bits; 1.0 = `32'h0000_8000`.
- `LR_SHIFT`, 0: error magnitude right-shift, 0..15; acts as the learning-rate scale.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `label_valid` in 1, `label_rdy` out 1, `label` in IDX_WIDTH: label handshake.
- `in_valid` in 1, `in_rdy` out 1, `in_data` in 32, `in_idx` in IDX_WIDTH: forward values from `fc`.
- `out_valid` out 1, `out_rdy` in 1, `out_data` out 32, `out_idx` out IDX_WIDTH: error stream to `fc`.
- `pred` out IDX_WIDTH: argmax of the last vector.
- `pred_valid` out 1: one-cycle pulse.
- `correct` out 1: `pred == label`; valid while `pred_valid` is high, held until the next pulse.
- `seq_err` out 1: sticky index-sequence error flag; cleared only by `rst`.

## Operation
- States: `IDLE`, `COLLECT`, `SEND`.
- **IDLE**
  - `label_rdy = 1`.
  - On `label_valid`: latch `label`, clear `cnt`/`max_val`/`max_idx`, go to `COLLECT`.
- **COLLECT**
  - `in_rdy = 1`.
  - Each `in_valid` beat is stored at position `cnt`, then `cnt++`.
  - If `in_idx != cnt`, set `seq_err`; the value is still stored at `cnt`.
  - Stored value: `err[cnt] = qsub(in_data, cnt == label ? 1.0 : 0)`, then magnitude `>> LR_SHIFT`.
  - Zero magnitude always gets sign 0 (no negative zero).
  - Argmax compare is sign-magnitude: any positive value beats any negative value.
  - Ties keep the lower index. Index 0 initialises `max_val` unconditionally.
  - After beat `OUTPUT_WIDTH-1`: set `pred = max_idx` and `correct`, pulse `pred_valid`, go to `SEND`.
  - Label `>= OUTPUT_WIDTH`: all targets are 0 and `correct = 0`.
- **SEND**
  - `out_valid = 1`, `out_idx = scnt`, `out_data = err[scnt]`.
  - Advance `scnt` on `out_valid & out_rdy`.
  - After the handshake at `scnt = OUTPUT_WIDTH-1`: go to `IDLE`.
- Arithmetic:
  - `qsub` is sign-magnitude add of `a` and the negated target; 31-bit magnitudes.
  - Overflow wraps the magnitude (no saturation).
  - Shift truncates toward zero.

## Timing
- Reset values (asynchronous, immediate): state `IDLE`, `in_rdy = 0`, `label_rdy = 1`, `out_valid = 0`, `out_data = 0`, `out_idx = 0`, `pred = 0`, `pred_valid = 0`, `correct = 0`, `seq_err = 0`, all counters 0.
- `label_rdy`, `in_rdy` and `out_valid` are decoded from registered state; no combinational path from inputs to outputs.
- A label accepted at edge k puts the block in `COLLECT` at k+1.
- The last input beat at edge k gives `pred_valid` high for cycle k+1 and `out_valid` high from k+1.
- Throughput: one input beat per cycle; one output beat per cycle while `out_rdy` is high.
- `out_data`/`out_idx` stay stable while `out_valid & !out_rdy`.
- `in_valid` outside `COLLECT` is ignored (`in_rdy = 0`). `label_valid` outside `IDLE` is ignored.
- After the final output handshake, `label_rdy` rises the next cycle. The minimum frame is 1 + OUTPUT_WIDTH + OUTPUT_WIDTH cycles.
- `rst` asserted mid-`COLLECT` or mid-`SEND` aborts the frame. No partial output follows.

## Structure
- Shared package `fc_pkg` holds:
  - `N`, `Q`, and `Q_ONE = 32'h0000_8000`;
  - the sign-magnitude `qadd`/`qmult` functions and a `sm_gt` compare function, shared with `fc`;
  - state encodings `LG_IDLE`, `LG_COLLECT`, `LG_SEND`.
- The error buffer is a register array `[OUTPUT_WIDTH-1:0][31:0]`; no RAM.
- One sub-module is natural: `sm_argmax`, a sequential running max with inputs `clear`/`en`/`val`/`idx` and outputs `max_idx`/`max_val`.

## Test plan
- **Basic:** label 3, inputs `0x8000` at idx 3 and 0 elsewhere → pred 3, correct 1, all errors 0, out_idx 0..9 in order.
- **Negative error:** label 2, idx 2 = `0x4000` (0.5), others 0, idx 7 = `0x6000` → err[2] = `0x8000_4000`, err[7] = `0x6000`, pred 7, correct 0.
- **Ties and signs:** all inputs `0x2000` → pred 0. Inputs with idx 0 = `0x8000_1000` and idx 1 = 0 → pred 1. Zero minus zero gives sign 0.
- **Backpressure:** hold `out_rdy` low for 5 cycles at `scnt = 4` → out_idx stays 4 and data is stable. Then exactly 10 beats total.
- **Errors:** send in_idx 0,1,3,… → `seq_err` = 1 and stays 1. Label 12 → all err = input, correct 0. `LR_SHIFT = 2` with input `0x8000` (1.0) on a non-label index → err = `0x2000`.
- **Reset:** assert `rst` for one cycle after 4 input beats → outputs immediately hold reset values. The next label and 10 beats complete normally.
